// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
//   Shared constants for the fetch->decode instruction queue.
//   - INST_WIDTH_DEF : default instruction word width
//   - DEPTH_DEF      : default queue depth (power of two, >= 2)
//   - RV32_LOW_BITS  : low two bits of every 32-bit RISC-V encoding
//   - is_rv32_enc()  : true when a word carries a 32-bit encoding
// -----------------------------------------------------------------------------
package inst_queue_pkg;

    localparam int          INST_WIDTH_DEF = 32;
    localparam int          DEPTH_DEF      = 4;
    localparam logic [1:0]  RV32_LOW_BITS  = 2'b11;

    function automatic logic is_rv32_enc(input logic [1:0] low_bits);
        return low_bits == RV32_LOW_BITS;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// -----------------------------------------------------------------------------
// inst_queue_if
//   Fetch-side and decode-side signals of the instruction queue.
//   Handshake: fetch pushes whenever uop_valid_in is high (it must itself stop
//   issuing when busy is high); decode takes the head entry on a rising edge
//   where consume and inst_valid are both high. consume with inst_valid low
//   is ignored.
//   Signals:
//     uop_valid_in  fetch -> queue   valid instruction this cycle
//     opcode_in     fetch -> queue   instruction word
//     busy          queue -> fetch   back-pressure (count >= DEPTH-1)
//     consume       decode -> queue  decode takes head entry
//     inst_valid    queue -> decode  head entry valid
//     inst_out      queue -> decode  head instruction word
//     inst_illegal  queue -> decode  head is not a 32-bit encoding
//   modport master : the fetch/decode side; modport slave : the queue.
// -----------------------------------------------------------------------------
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int INST_WIDTH = INST_WIDTH_DEF
);
    logic                  uop_valid_in;
    logic [INST_WIDTH-1:0] opcode_in;
    logic                  busy;
    logic                  consume;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst_out;
    logic                  inst_illegal;

    modport master (
        output uop_valid_in, opcode_in, consume,
        input  busy, inst_valid, inst_out, inst_illegal
    );

    modport slave (
        input  uop_valid_in, opcode_in, consume,
        output busy, inst_valid, inst_out, inst_illegal
    );
endinterface

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Circular FIFO between fetch and decode. Every valid uop from fetch is
//   stored; the oldest entry is presented to decode. Supports flush and
//   records dropped pushes in a sticky overflow flag.
//   Ports:
//     clk           rising-edge clock
//     reset         asynchronous active-high reset
//     q             inst_queue_if.slave (fetch push / decode pop handshake)
//     flush         discard all queued entries (highest priority)
//     count         number of occupied entries
//     overflow_err  sticky: a push arrived while full without a pop
// -----------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    inst_queue_if.slave                q,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] BUSY_CNT = CW'(DEPTH - 1);

    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic push;
    logic pop;
    logic full;
    logic do_write;

    assign full     = (count == FULL_CNT);
    assign push     = q.uop_valid_in;
    // Pop only when there is something to take; consume on empty is a no-op,
    // which also rules out any push->pop bypass on an empty queue.
    assign pop      = q.consume && (count != '0);
    // When full, a push is only accepted if the pop frees a slot this cycle.
    assign do_write = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= q.opcode_in;
                wr_ptr      <= wr_ptr + 1'b1;   // PW bits wrap modulo DEPTH
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_write) begin
                count <= count - 1'b1;
            end
            if (push && !do_write) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign q.inst_valid   = (count != '0);
    assign q.inst_out     = mem[rd_ptr];
    assign q.inst_illegal = q.inst_valid && !is_rv32_enc(mem[rd_ptr][1:0]);
    // One slot of slack for a uop already in flight inside fetch.
    assign q.busy         = (count >= BUSY_CNT);

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//   Directed bench for inst_queue (DEPTH=4, INST_WIDTH=32). Inputs change
//   1 time unit after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_inst_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [2:0]  count;
    logic        overflow_err;

    int n_checks;
    int n_fail;

    inst_queue_if #(.INST_WIDTH(32)) qif ();

    inst_queue #(.DEPTH(4), .INST_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .q            (qif),
        .flush        (flush),
        .count        (count),
        .overflow_err (overflow_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 unit after the edge
    // with inputs back to idle.
    task automatic cyc(input logic psh, input logic [31:0] op,
                       input logic cons, input logic fl);
        qif.uop_valid_in = psh;
        qif.opcode_in    = op;
        qif.consume      = cons;
        flush            = fl;
        @(posedge clk);
        #1;
        qif.uop_valid_in = 1'b0;
        qif.opcode_in    = '0;
        qif.consume      = 1'b0;
        flush            = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset            = 1'b1;
        flush            = 1'b0;
        qif.uop_valid_in = 1'b0;
        qif.opcode_in    = '0;
        qif.consume      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",   32'(count), 32'd0);
        chk("rst_valid",   32'(qif.inst_valid), 32'd0);
        chk("rst_busy",    32'(qif.busy), 32'd0);
        chk("rst_ovf",     32'(overflow_err), 32'd0);
        chk("rst_out",     qif.inst_out, 32'h0);
        chk("rst_illegal", 32'(qif.inst_illegal), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: reset mid-operation with 3 entries
        cyc(1'b1, 32'h0000_00A3, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_00B3, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_00C3, 1'b0, 1'b0);
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_busy3",  32'(qif.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t1_rst_count", 32'(count), 32'd0);
        chk("t1_rst_valid", 32'(qif.inst_valid), 32'd0);
        chk("t1_rst_busy",  32'(qif.busy), 32'd0);
        chk("t1_rst_ovf",   32'(overflow_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0);
        chk("t1_head",  qif.inst_out, 32'h0000_0013);
        chk("t1_valid", 32'(qif.inst_valid), 32'd1);
        chk("t1_cnt1",  32'(count), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_drain", 32'(count), 32'd0);

        // 2: fill
        cyc(1'b1, 32'h11, 1'b0, 1'b0);
        chk("t2_busy1", 32'(qif.busy), 32'd0);
        chk("t2_ill11", 32'(qif.inst_illegal), 32'd1);
        cyc(1'b1, 32'h23, 1'b0, 1'b0);
        chk("t2_busy2", 32'(qif.busy), 32'd0);
        cyc(1'b1, 32'h33, 1'b0, 1'b0);
        chk("t2_busy3", 32'(qif.busy), 32'd1);
        chk("t2_cnt3",  32'(count), 32'd3);
        cyc(1'b1, 32'h43, 1'b0, 1'b0);
        chk("t2_cnt4",  32'(count), 32'd4);
        chk("t2_head",  qif.inst_out, 32'h11);

        // 3: overflow
        cyc(1'b1, 32'hDEAD_0003, 1'b0, 1'b0);
        chk("t3_cnt",  32'(count), 32'd4);
        chk("t3_ovf",  32'(overflow_err), 32'd1);
        chk("t3_head", qif.inst_out, 32'h11);

        // 4: push+pop while full
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        chk("t4_cnt",  32'(count), 32'd4);
        chk("t4_head", qif.inst_out, 32'h23);
        chk("t4_ovf",  32'(overflow_err), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_h33", qif.inst_out, 32'h33);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_h43", qif.inst_out, 32'h43);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_h55", qif.inst_out, 32'h55);
        chk("t4_cnt1", 32'(count), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_empty", 32'(qif.inst_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_pop_empty", 32'(count), 32'd0);

        // 5: flush beats same-cycle push and pop
        cyc(1'b1, 32'h0000_0103, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0203, 1'b0, 1'b0);
        chk("t5_cnt2", 32'(count), 32'd2);
        cyc(1'b1, 32'h0000_0303, 1'b1, 1'b1);
        chk("t5_cnt0",  32'(count), 32'd0);
        chk("t5_valid", 32'(qif.inst_valid), 32'd0);
        chk("t5_ovf",   32'(overflow_err), 32'd1);
        cyc(1'b1, 32'h0000_0403, 1'b0, 1'b0);
        chk("t5_alone_cnt",  32'(count), 32'd1);
        chk("t5_alone_head", qif.inst_out, 32'h0000_0403);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_drain", 32'(count), 32'd0);

        // 6: wrap with back-to-back push+pop, then illegal head
        cyc(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            v = 32'h0000_0003 | (32'(i) << 8);
            chk("t6_order", qif.inst_out, v);
            cyc(1'b1, 32'h0000_0003 | (32'(i + 1) << 8), 1'b1, 1'b0);
            chk("t6_cnt", 32'(count), 32'd1);
        end
        chk("t6_last", qif.inst_out, 32'h0000_0A03);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0000_0010, 1'b0, 1'b0);
        chk("t6_ill",      32'(qif.inst_illegal), 32'd1);
        chk("t6_ill_head", qif.inst_out, 32'h0000_0010);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t6_ill_gone", 32'(qif.inst_illegal), 32'd0);
        chk("t6_ovf_sticky", 32'(overflow_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
